// File: rtl/spm_rr_arbiter.sv
// spm_rr_arbiter: round-robin front end that shares a single signed
// serial-parallel multiplier among N_REQ requesters. One operation is in
// flight at a time. A watchdog aborts an operation whose done never arrives.
module spm_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 R,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   x_in,
    input  logic [N_REQ*W-1:0]   y_in,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [2*W-1:0]       rsp_p,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [W-1:0]         spm_X,
    output logic [W-1:0]         spm_Y,
    output logic                 spm_Go,
    output logic                 spm_R,
    input  logic                 spm_done,
    input  logic [2*W-1:0]       spm_P
);

    localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RESP    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    // Round-robin scan starting at p; returns {found, index}. The scan runs
    // from the far end back toward p so the lowest offset from p wins.
    function automatic logic [IW:0] pick_winner(input logic [N_REQ-1:0] r,
                                                 input logic [IW-1:0]    p);
        logic [IW:0] res;
        int          idx;
        res = {(IW+1){1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (r[idx]) begin
                res = {1'b1, IW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Requester index to one-hot vector.
    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
        return {{(N_REQ-1){1'b0}}, 1'b1} << i;
    endfunction

    logic [2:0]       state_q,  state_d;
    logic [IW-1:0]    ptr_q,    ptr_d;
    logic [IW-1:0]    win_q,    win_d;
    logic [WDW-1:0]   wd_q,     wd_d;
    logic [W-1:0]     x_q,      x_d;
    logic [W-1:0]     y_q,      y_d;
    logic [2*W-1:0]   p_q,      p_d;
    logic             err_q,    err_d;
    logic [N_REQ-1:0] grant_q,  grant_d;
    logic [N_REQ-1:0] vld_q,    vld_d;
    logic             go_q,     go_d;
    logic             sr_q,     sr_d;
    logic             busy_q,   busy_d;
    logic [IW:0]      pick_s;
    logic [IW-1:0]    pick_idx_s;

    assign pick_s     = pick_winner(req, ptr_q);
    assign pick_idx_s = pick_s[IW-1:0];

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        wd_d    = wd_q;
        x_d     = x_q;
        y_d     = y_q;
        p_d     = p_q;
        err_d   = err_q;
        grant_d = {N_REQ{1'b0}};
        vld_d   = {N_REQ{1'b0}};
        go_d    = 1'b0;
        sr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_s[IW]) begin
                    win_d   = pick_idx_s;
                    x_d     = x_in[pick_idx_s*W +: W];
                    y_d     = y_in[pick_idx_s*W +: W];
                    if (pick_idx_s == IW'(N_REQ - 1)) begin
                        ptr_d = {IW{1'b0}};
                    end else begin
                        ptr_d = pick_idx_s + IW'(1);
                    end
                    grant_d = onehot(pick_idx_s);
                    go_d    = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                wd_d    = {WDW{1'b0}};
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done level seen in the first WAIT cycle may be left over
                // from the previous operation, so it is ignored there.
                if ((wd_q != {WDW{1'b0}}) && spm_done) begin
                    p_d     = spm_P;
                    err_d   = 1'b0;
                    vld_d   = onehot(win_q);
                    state_d = S_RESP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    p_d     = {(2*W){1'b0}};
                    err_d   = 1'b1;
                    sr_d    = 1'b1;
                    state_d = S_RECOVER;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_RECOVER: begin
                vld_d   = onehot(win_q);
                state_d = S_RESP;
            end
            S_RESP: begin
                p_d     = {(2*W){1'b0}};
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= S_IDLE;
            ptr_q   <= {IW{1'b0}};
            win_q   <= {IW{1'b0}};
            wd_q    <= {WDW{1'b0}};
            x_q     <= {W{1'b0}};
            y_q     <= {W{1'b0}};
            p_q     <= {(2*W){1'b0}};
            err_q   <= 1'b0;
            grant_q <= {N_REQ{1'b0}};
            vld_q   <= {N_REQ{1'b0}};
            go_q    <= 1'b0;
            sr_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            wd_q    <= wd_d;
            x_q     <= x_d;
            y_q     <= y_d;
            p_q     <= p_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            vld_q   <= vld_d;
            go_q    <= go_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
        end
    end

    assign grant     = grant_q;
    assign rsp_valid = vld_q;
    assign rsp_p     = p_q;
    assign rsp_err   = err_q;
    assign busy      = busy_q;
    assign spm_X     = x_q;
    assign spm_Y     = y_q;
    assign spm_Go    = go_q;
    assign spm_R     = sr_q;

endmodule

// File: tb/tb_spm_rr_arbiter.sv
// Directed bench for spm_rr_arbiter with a behavioural SPM mock and a
// scoreboard of expected grant index / product / error flag.
module tb_spm_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 10;

    logic             clk = 1'b0;
    logic             R;
    logic [N-1:0]     req;
    logic [N*W-1:0]   x_in;
    logic [N*W-1:0]   y_in;
    logic [N-1:0]     grant;
    logic [N-1:0]     rsp_valid;
    logic [2*W-1:0]   rsp_p;
    logic             rsp_err;
    logic             busy;
    logic [W-1:0]     spm_X;
    logic [W-1:0]     spm_Y;
    logic             spm_Go;
    logic             spm_R;
    logic             spm_done;
    logic [2*W-1:0]   spm_P;

    spm_rr_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(32)) dut (
        .clk(clk), .R(R), .req(req), .x_in(x_in), .y_in(y_in),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_err(rsp_err),
        .busy(busy), .spm_X(spm_X), .spm_Y(spm_Y), .spm_Go(spm_Go), .spm_R(spm_R),
        .spm_done(spm_done), .spm_P(spm_P)
    );

    always #5 clk = ~clk;

    // Mock SPM: product after LAT cycles; done stays high until the next Go.
    logic                 hang;
    logic                 stale_mode;
    logic                 drop_pend;
    int                   cnt;
    logic signed [2*W-1:0] prod;

    initial begin
        spm_done = 1'b0; spm_P = '0; drop_pend = 1'b0; cnt = 0; prod = '0;
    end

    always @(posedge clk) begin
        if (spm_R) begin
            spm_done  <= 1'b0;
            drop_pend <= 1'b0;
            cnt       <= 0;
        end else if (spm_Go) begin
            spm_done  <= stale_mode ? spm_done : 1'b0;
            drop_pend <= stale_mode;
            cnt       <= LAT;
            prod      <= $signed(spm_X) * $signed(spm_Y);
        end else begin
            if (drop_pend) begin
                spm_done  <= 1'b0;
                drop_pend <= 1'b0;
            end
            if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1 && !hang) begin
                    spm_done <= 1'b1;
                    spm_P    <= prod;
                end
            end
        end
    end

    typedef struct {
        int          idx;
        logic [15:0] p;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   last_n   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y);
        x_in[i*W +: W] = x;
        y_in[i*W +: W] = y;
    endtask

    task automatic push(input int i, input logic [15:0] p, input logic err);
        exp_t e;
        e.idx = i; e.p = p; e.err = err;
        sb.push_back(e);
    endtask

    task automatic wait_grant(input int exp_idx, input logic [N-1:0] req_after);
        int n;
        n = 0;
        while (grant == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        last_n = n;
        check("grant_seen", {31'd0, grant != '0}, 32'd1);
        check("grant_idx", {28'd0, grant}, 32'd1 << exp_idx);
        check("go_with_grant", {31'd0, spm_Go}, 32'd1);
        check("busy_in_issue", {31'd0, busy}, 32'd1);
        req = req_after;
    endtask

    task automatic wait_rsp(input exp_t e);
        int n;
        n = 0;
        while (rsp_valid == '0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid", {28'd0, rsp_valid}, 32'd1 << e.idx);
        check("rsp_p", {16'd0, rsp_p}, {16'd0, e.p});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        @(negedge clk);
    endtask

    task automatic run_next(input logic [N-1:0] req_after);
        exp_t e;
        e = sb.pop_front();
        wait_grant(e.idx, req_after);
        wait_rsp(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        R = 1'b1;
        @(negedge clk);
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("rst_rsp_p", {16'd0, rsp_p}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_spm_x", {24'd0, spm_X}, 32'd0);
        check("rst_spm_y", {24'd0, spm_Y}, 32'd0);
        check("rst_spm_go", {31'd0, spm_Go}, 32'd0);
        check("rst_spm_r", {31'd0, spm_R}, 32'd1);
        R = 1'b0;
        @(negedge clk);
        check("spm_r_released", {31'd0, spm_R}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    logic [15:0] rr_p [4];
    int          n;
    int          cnt_ev;

    initial begin
        R = 1'b1; req = '0; x_in = '0; y_in = '0; hang = 1'b0; stale_mode = 1'b0;
        rr_p[0] = 16'hFFFE; rr_p[1] = 16'hFFFA; rr_p[2] = 16'hFFF4; rr_p[3] = 16'hFFEC;
        repeat (2) @(negedge clk);
        do_reset();

        // Single request: -4 * 3
        set_op(0, 8'hFC, 8'h03);
        push(0, 16'hFFF4, 1'b0);
        req = 4'b0001;
        begin
            exp_t e;
            e = sb.pop_front();
            wait_grant(e.idx, 4'b0000);
            check("grant_latency", last_n, 32'd1);
            check("spm_x_latched", {24'd0, spm_X}, 32'h000000FC);
            check("spm_y_latched", {24'd0, spm_Y}, 32'h00000003);
            wait_rsp(e);
        end
        check("busy_after_resp", {31'd0, busy}, 32'd0);

        // Corner operands on requester 2
        set_op(2, 8'h80, 8'h80);
        push(2, 16'h4000, 1'b0);
        req = 4'b0100;
        run_next(4'b0000);
        set_op(2, 8'h7F, 8'h80);
        push(2, 16'hC080, 1'b0);
        req = 4'b0100;
        run_next(4'b0000);

        // Round-robin with all requesters held high from ptr=0
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 8'(i + 1), 8'(-(i + 2)));
        for (int k = 0; k < 6; k++) push(k % N, rr_p[k % N], 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 6; k++) run_next((k == 5) ? 4'b0000 : 4'b1111);

        do_reset();
        push(1, rr_p[1], 1'b0); push(3, rr_p[3], 1'b0); push(1, rr_p[1], 1'b0);
        req = 4'b1010;
        for (int k = 0; k < 3; k++) run_next((k == 2) ? 4'b0000 : 4'b1010);

        // Stale done held through the first WAIT cycle
        stale_mode = 1'b1;
        set_op(0, 8'h05, 8'hF9);
        push(0, 16'hFFDD, 1'b0);
        req = 4'b0001;
        run_next(4'b0000);
        stale_mode = 1'b0;

        // Timeout: done never comes
        hang = 1'b1;
        set_op(0, 8'h03, 8'h03);
        req = 4'b0001;
        wait_grant(0, 4'b0000);
        n = 0;
        while (!spm_R && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, 32'd33);
        @(negedge clk);
        check("spm_r_pulse_len", {31'd0, spm_R}, 32'd0);
        check("to_rsp_valid", {28'd0, rsp_valid}, 32'd1);
        check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
        check("to_rsp_p", {16'd0, rsp_p}, 32'd0);
        @(negedge clk);
        hang = 1'b0;
        set_op(3, 8'hFF, 8'hFF);
        push(3, 16'h0001, 1'b0);
        req = 4'b1000;
        run_next(4'b0000);

        // Reset during WAIT aborts with no response, ptr back to 0
        set_op(0, 8'h02, 8'h02);
        set_op(1, 8'h06, 8'h06);
        req = 4'b0001;
        wait_grant(0, 4'b0000);
        repeat (3) @(negedge clk);
        R = 1'b1;
        @(negedge clk);
        check("abort_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_spm_x", {24'd0, spm_X}, 32'd0);
        check("abort_spm_go", {31'd0, spm_Go}, 32'd0);
        check("abort_spm_r", {31'd0, spm_R}, 32'd1);
        R = 1'b0;
        cnt_ev = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) cnt_ev++;
        end
        check("abort_no_rsp", cnt_ev, 32'd0);
        push(0, 16'h0004, 1'b0);
        req = 4'b0011;
        run_next(4'b0000);

        // Requester 1 withdraws while requester 0 is in WAIT
        push(0, 16'h0004, 1'b0);
        req = 4'b0001;
        begin
            exp_t e;
            e = sb.pop_front();
            wait_grant(e.idx, 4'b0000);
            repeat (2) @(negedge clk);
            req = 4'b0010;
            repeat (3) @(negedge clk);
            req = 4'b0000;
            wait_rsp(e);
        end
        cnt_ev = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (grant != '0) cnt_ev++;
        end
        check("withdraw_no_grant", cnt_ev, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
